// File: rtl/sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkg
// Shared definitions for the synchronous FIFO slice.
//   ptrWidth()     : read/write pointer width (index bits + one wrap bit)
//   countWidth()   : occupancy counter width (must hold 0..DEPTH inclusive)
//   DROP_CNT_W     : width of the dropped-write statistics counter
//   DROP_CNT_MAX   : value at which the dropped-write counter saturates
// ---------------------------------------------------------------------------
package sync_fifo_pkg;

   localparam int DROP_CNT_W = 8;
   localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

   // Pointers carry one extra MSB so that full and empty are distinguishable
   // after the index bits wrap from DEPTH-1 back to 0.
   function automatic int ptrWidth(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // The counter has to represent DEPTH itself, which needs one bit more
   // than the index range.
   function automatic int countWidth(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// ---------------------------------------------------------------------------
// fifo_mem_2p
// DATA_W x DEPTH storage array with one synchronous write port and one
// asynchronous (combinational) read port. The array is deliberately not
// reset: contents are only meaningful where the controller says they are.
// Ports:
//   clock   : write clock, rising edge
//   wrEn    : write enable
//   wrAddr  : write index
//   wrData  : write word
//   rdAddr  : read index
//   rdData  : word currently stored at rdAddr
// ---------------------------------------------------------------------------
module fifo_mem_2p #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8
)(
   input  logic                     clock,
   input  logic                     wrEn,
   input  logic [$clog2(DEPTH)-1:0] wrAddr,
   input  logic [DATA_W-1:0]        wrData,
   input  logic [$clog2(DEPTH)-1:0] rdAddr,
   output logic [DATA_W-1:0]        rdData
);

   logic [DATA_W-1:0] memArray [DEPTH];

   // Write port: a single word is captured on the rising edge when enabled.
   // No reset here, so this maps cleanly onto RAM or distributed memory.
   always_ff @(posedge clock) begin
      if (wrEn) begin
         memArray[wrAddr] <= wrData;
      end
   end

   // Read port is purely combinational so the FIFO can present its oldest
   // word show-ahead style, with no extra read latency.
   assign rdData = memArray[rdAddr];

endmodule

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
// Parameterised single-clock show-ahead FIFO with valid/ready handshakes on
// both sides, an occupancy count and almost-full / almost-empty flags.
// Optional overflow statistics are compiled in when the macro
// SYNC_FIFO_ERR_STATS_EN is defined.
// Parameters:
//   DATA_W : word width in bits
//   DEPTH  : number of entries (power of two, >= 2)
//   AF_LVL : almost_full asserts when count >= AF_LVL
//   AE_LVL : almost_empty asserts when count <= AE_LVL
// Ports:
//   fifo_clk     : clock, all logic on the rising edge
//   fifo_rst     : asynchronous active-high reset
//   wr_valid     : producer offers wr_data
//   wr_data      : write word
//   wr_ready     : FIFO has space (count != DEPTH)
//   rd_valid     : rd_data holds the oldest stored word (count != 0)
//   rd_data      : oldest stored word
//   rd_ready     : consumer takes rd_data this cycle
//   count        : current occupancy, 0..DEPTH
//   almost_full  : count >= AF_LVL
//   almost_empty : count <= AE_LVL
//   ovf_err      : (SYNC_FIFO_ERR_STATS_EN only) sticky write-while-full flag
//   drop_cnt     : (SYNC_FIFO_ERR_STATS_EN only) saturating dropped-write count
//   err_clr      : (SYNC_FIFO_ERR_STATS_EN only) clears ovf_err and drop_cnt
// ---------------------------------------------------------------------------
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int AF_LVL = DEPTH - 2,
   parameter int AE_LVL = 2
)(
   input  logic                         fifo_clk,
   input  logic                         fifo_rst,
   input  logic                         wr_valid,
   input  logic [DATA_W-1:0]            wr_data,
   output logic                         wr_ready,
   output logic                         rd_valid,
   output logic [DATA_W-1:0]            rd_data,
   input  logic                         rd_ready,
   output logic [countWidth(DEPTH)-1:0] count,
   output logic                         almost_full,
   output logic                         almost_empty
`ifdef SYNC_FIFO_ERR_STATS_EN
   ,
   output logic                         ovf_err,
   output logic [DROP_CNT_W-1:0]        drop_cnt,
   input  logic                         err_clr
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = ptrWidth(DEPTH);
   localparam int CW = countWidth(DEPTH);

   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_COUNT   = CW'(AF_LVL);
   localparam logic [CW-1:0] AE_COUNT   = CW'(AE_LVL);

   logic [PW-1:0] wrPtr;
   logic [PW-1:0] rdPtr;
   logic          doPush;
   logic          doPop;

   // Handshake status comes straight from the registered count, so there is
   // no combinational path from wr_valid/rd_ready to wr_ready/rd_valid.
   // Because wr_ready is low when full, a write is ignored at full even if
   // a pop happens in the same cycle; likewise nothing bypasses an empty FIFO.
   assign wr_ready = (count != FULL_COUNT);
   assign rd_valid = (count != '0);
   assign doPush   = wr_valid && wr_ready;
   assign doPop    = rd_valid && rd_ready;

   // Level flags are plain compares on the registered count and therefore
   // work for any threshold in 0..DEPTH, including the degenerate ends.
   assign almost_full  = (count >= AF_COUNT);
   assign almost_empty = (count <= AE_COUNT);

   // Pointer and occupancy registers. Pointers just increment and roll over
   // naturally; only the low AW bits address storage and the MSB tracks the
   // wrap. The count moves by one only when exactly one side transfers, so a
   // simultaneous push and pop leaves it unchanged. Reset drops everything.
   always_ff @(posedge fifo_clk or posedge fifo_rst) begin
      if (fifo_rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + PW'(1);
         end
         if (doPop) begin
            rdPtr <= rdPtr + PW'(1);
         end
         case ({doPush, doPop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   fifo_mem_2p #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clock  (fifo_clk),
      .wrEn   (doPush),
      .wrAddr (wrPtr[AW-1:0]),
      .wrData (wr_data),
      .rdAddr (rdPtr[AW-1:0]),
      .rdData (rd_data)
   );

`ifdef SYNC_FIFO_ERR_STATS_EN
   logic dropNow;

   assign dropNow = wr_valid && !wr_ready;

   // Overflow statistics: any offered write refused for lack of space sets a
   // sticky flag and bumps a saturating counter. A clear request takes
   // priority over a drop arriving on the same edge.
   always_ff @(posedge fifo_clk or posedge fifo_rst) begin
      if (fifo_rst) begin
         ovf_err  <= 1'b0;
         drop_cnt <= '0;
      end else if (err_clr) begin
         ovf_err  <= 1'b0;
         drop_cnt <= '0;
      end else if (dropNow) begin
         ovf_err <= 1'b1;
         if (drop_cnt != DROP_CNT_MAX) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
// Directed self-checking bench for sync_fifo_param at its default
// configuration (DATA_W=32, DEPTH=8, AF_LVL=6, AE_LVL=2). The overflow
// statistics section is only built when SYNC_FIFO_ERR_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;

   logic        fifo_clk;
   logic        fifo_rst;
   logic        wr_valid;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        rd_ready;
   logic [3:0]  count;
   logic        almost_full;
   logic        almost_empty;
`ifdef SYNC_FIFO_ERR_STATS_EN
   logic        ovf_err;
   logic [7:0]  drop_cnt;
   logic        err_clr;
`endif

   int checkCount = 0;
   int errorCount = 0;

   sync_fifo_param dut (
      .fifo_clk     (fifo_clk),
      .fifo_rst     (fifo_rst),
      .wr_valid     (wr_valid),
      .wr_data      (wr_data),
      .wr_ready     (wr_ready),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .rd_ready     (rd_ready),
      .count        (count),
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
`ifdef SYNC_FIFO_ERR_STATS_EN
      ,
      .ovf_err      (ovf_err),
      .drop_cnt     (drop_cnt),
      .err_clr      (err_clr)
`endif
   );

   // 100 MHz free-running clock, first rising edge at 5 ns.
   initial begin
      fifo_clk = 1'b0;
      forever #5 fifo_clk = ~fifo_clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of handshake inputs, let the next rising edge take them,
   // and return 1 ns after that edge so outputs are sampled away from it.
   task automatic applyStimulus(input logic wv, input logic [31:0] wd, input logic rr);
      wr_valid = wv;
      wr_data  = wd;
      rd_ready = rr;
      @(posedge fifo_clk);
      #1;
   endtask

   // Main directed sequence.
   initial begin
      fifo_rst = 1'b0;
      wr_valid = 1'b0;
      wr_data  = '0;
      rd_ready = 1'b0;
`ifdef SYNC_FIFO_ERR_STATS_EN
      err_clr  = 1'b0;
`endif

      // Reset values, taken while reset is still held.
      #2 fifo_rst = 1'b1;
      #1;
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
      checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("rst_almost_empty", 32'(almost_empty), 32'd1);
      checkOutput("rst_almost_full", 32'(almost_full), 32'd0);
      @(posedge fifo_clk);
      #1 fifo_rst = 1'b0;

      // Fill with 0x11..0x88, flags tracked after every push.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 32'((i + 1) * 32'h11), 1'b0);
         checkOutput("fill_count", 32'(count), 32'(i + 1));
         checkOutput("fill_almost_full", 32'(almost_full), 32'((i + 1) >= 6));
         checkOutput("fill_almost_empty", 32'(almost_empty), 32'((i + 1) <= 2));
         checkOutput("fill_wr_ready", 32'(wr_ready), 32'((i + 1) != 8));
         checkOutput("fill_head", rd_data, 32'h11);
      end

      // Drain in order; head must already be presented before each pop.
      for (int i = 0; i < 8; i++) begin
         checkOutput("drain_rd_valid", 32'(rd_valid), 32'd1);
         checkOutput("drain_data", rd_data, 32'((i + 1) * 32'h11));
         applyStimulus(1'b0, 32'h0, 1'b1);
         checkOutput("drain_count", 32'(count), 32'(7 - i));
      end
      checkOutput("drained_rd_valid", 32'(rd_valid), 32'd0);

      // Popping an empty FIFO must not underflow.
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("underflow_count", 32'(count), 32'd0);

      // Refill, then offer a write and a read together while full:
      // only the pop may happen.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 32'(32'h200 + i), 1'b0);
      end
      checkOutput("full_count", 32'(count), 32'd8);
      applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1);
      checkOutput("full_pushpop_count", 32'(count), 32'd7);
      checkOutput("full_pushpop_wr_ready", 32'(wr_ready), 32'd1);
      for (int i = 1; i < 8; i++) begin
         checkOutput("full_pushpop_order", rd_data, 32'(32'h200 + i));
         applyStimulus(1'b0, 32'h0, 1'b1);
      end
      checkOutput("full_pushpop_empty", 32'(rd_valid), 32'd0);

      // One-cycle write-to-read latency from empty.
      applyStimulus(1'b1, 32'hA5A5_A5A5, 1'b0);
      checkOutput("latency_rd_valid", 32'(rd_valid), 32'd1);
      checkOutput("latency_rd_data", rd_data, 32'hA5A5_A5A5);
      applyStimulus(1'b0, 32'h0, 1'b1);

      // Steady state at count=4 with push and pop every cycle for 20 cycles;
      // pointers cross the DEPTH-1 -> 0 boundary several times.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'(32'h100 + i), 1'b0);
      end
      for (int c = 0; c < 20; c++) begin
         checkOutput("stream_head", rd_data, 32'(32'h100 + c));
         applyStimulus(1'b1, 32'(32'h104 + c), 1'b1);
         checkOutput("stream_count", 32'(count), 32'd4);
      end
      for (int i = 0; i < 4; i++) begin
         checkOutput("stream_tail", rd_data, 32'(32'h114 + i));
         applyStimulus(1'b0, 32'h0, 1'b1);
      end
      checkOutput("stream_empty", 32'(count), 32'd0);

      // Asynchronous reset at count=5, observed before any clock edge.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 32'(32'h300 + i), 1'b0);
      end
      checkOutput("pre_rst_count", 32'(count), 32'd5);
      #2 fifo_rst = 1'b1;
      #1;
      checkOutput("async_rst_count", 32'(count), 32'd0);
      checkOutput("async_rst_rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("async_rst_wr_ready", 32'(wr_ready), 32'd1);
      // A push offered across an edge while reset is held does nothing.
      applyStimulus(1'b1, 32'h0BAD_0BAD, 1'b1);
      checkOutput("rst_held_push_count", 32'(count), 32'd0);
      fifo_rst = 1'b0;
      applyStimulus(1'b1, 32'h0000_0077, 1'b0);
      checkOutput("post_rst_count", 32'(count), 32'd1);
      checkOutput("post_rst_data", rd_data, 32'h0000_0077);
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkOutput("post_rst_empty", 32'(rd_valid), 32'd0);

`ifdef SYNC_FIFO_ERR_STATS_EN
      // Clear any statistics gathered earlier, then exercise overflow.
      fifo_rst = 1'b1;
      #1;
      checkOutput("stats_rst_ovf", 32'(ovf_err), 32'd0);
      checkOutput("stats_rst_drop", 32'(drop_cnt), 32'd0);
      fifo_rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 32'(32'h400 + i), 1'b0);
      end
      checkOutput("stats_no_drop_yet", 32'(drop_cnt), 32'd0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'hFFFF_0000, 1'b0);
      end
      checkOutput("stats_ovf_err", 32'(ovf_err), 32'd1);
      checkOutput("stats_drop3", 32'(drop_cnt), 32'd3);
      checkOutput("stats_full_kept", 32'(count), 32'd8);
      err_clr = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("stats_clr_ovf", 32'(ovf_err), 32'd0);
      checkOutput("stats_clr_drop", 32'(drop_cnt), 32'd0);
      // Clear wins over a drop on the same edge.
      applyStimulus(1'b1, 32'h0, 1'b0);
      checkOutput("stats_clr_wins_ovf", 32'(ovf_err), 32'd0);
      checkOutput("stats_clr_wins_drop", 32'(drop_cnt), 32'd0);
      err_clr = 1'b0;
      for (int i = 0; i < 255; i++) begin
         applyStimulus(1'b1, 32'h0, 1'b0);
      end
      checkOutput("stats_drop255", 32'(drop_cnt), 32'd255);
      for (int i = 0; i < 45; i++) begin
         applyStimulus(1'b1, 32'h0, 1'b0);
      end
      checkOutput("stats_drop_sat", 32'(drop_cnt), 32'd255);
      checkOutput("stats_ovf_sticky", 32'(ovf_err), 32'd1);
      // Contents survive the overflow attempts untouched.
      applyStimulus(1'b0, 32'h0, 1'b0);
      checkOutput("stats_head_intact", rd_data, 32'h400);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

   // Safety net so the run always ends even if the sequence stalls.
   initial begin
      #200000;
      errorCount++;
      $display("[TB] FAIL timeout: observed no completion expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, number of storage entries (power of two, >=2).
REQ-003 SHALL have parameter AF_LVL, default DEPTH-2, occupancy at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LVL, default 2, occupancy at or below which almost_empty asserts.
REQ-005 SHALL have port fifo_clk  input  1  single clock, all logic rising-edge.
REQ-006 SHALL have port fifo_rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port wr_valid  input  1  producer offers wr_data.
REQ-008 SHALL have port wr_data  input  DATA_W  write word.
REQ-009 SHALL have port wr_ready  output  1  FIFO can accept a word.
REQ-010 SHALL have port rd_valid  output  1  rd_data holds the oldest stored word.
REQ-011 SHALL have port rd_data  output  DATA_W  oldest stored word (show-ahead).
REQ-012 SHALL have port rd_ready  input  1  consumer takes rd_data.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 SHALL have port almost_full  output  1  count >= AF_LVL.
REQ-015 SHALL have port almost_empty  output  1  count <= AE_LVL.
REQ-016 SHALL have ports ovf_err  output  1, drop_cnt  output  8, err_clr  input  1 (present only per REQ-033).

Function
REQ-017 Push SHALL occur on a rising edge where wr_valid && wr_ready; pop where rd_valid && rd_ready.
REQ-018 wr_ready SHALL equal (count != DEPTH); rd_valid SHALL equal (count != 0); both combinational from registered state.
REQ-019 rd_data SHALL be mem[rd_ptr] combinationally; stays stable while rd_valid && !rd_ready.
REQ-020 Latency: word pushed at edge N SHALL appear on rd_data with rd_valid=1 after edge N when FIFO was empty (1-cycle write-to-read).
REQ-021 Simultaneous push and pop SHALL both occur in the same cycle; count unchanged; supported at every occupancy 1..DEPTH-1.
REQ-022 When full, wr_valid SHALL be ignored even if a pop occurs that cycle (no pass-through); when empty, no read bypass.
REQ-023 Pointers SHALL be $clog2(DEPTH)+1 bits; index = low bits, MSB = wrap bit; wrap from DEPTH-1 to 0 SHALL be seamless.
REQ-024 count SHALL be registered: +1 push only, -1 pop only, unchanged otherwise; never exceeds DEPTH or underflows 0.
REQ-025 almost_full/almost_empty SHALL be combinational compares on count, valid for any AF_LVL/AE_LVL in 0..DEPTH.
REQ-026 Output data order SHALL be strict FIFO; no word lost, duplicated or reordered.

Reset
REQ-027 fifo_rst=1 SHALL asynchronously clear wr_ptr, rd_ptr, count to 0, giving wr_ready=1, rd_valid=0, almost_empty=1, almost_full=(AF_LVL==0).
REQ-028 Reset asserted mid-transfer SHALL discard all contents; a push/pop coinciding with the reset edge SHALL have no effect.
REQ-029 Storage array SHALL not be reset; rd_data is don't-care while rd_valid=0.
REQ-030 ovf_err and drop_cnt SHALL reset to 0.

Configuration
REQ-031 Macro SYNC_FIFO_ERR_STATS_EN SHALL control the overflow statistics feature.
REQ-032 Defined: ovf_err sets on any edge with wr_valid && !wr_ready, sticky until err_clr; drop_cnt increments on such edges, saturates at 255; err_clr clears both (err_clr wins over a simultaneous drop).
REQ-033 Undefined: ovf_err, drop_cnt, err_clr ports and their logic SHALL not exist; all other behaviour identical.

Structure
REQ-034 Package sync_fifo_pkg SHALL hold the pointer/count width functions, drop-counter width constant (8) and the saturation max.
REQ-035 Storage SHALL be sub-module fifo_mem_2p (DATA_W x DEPTH, one sync write port, one async read port); control stays in sync_fifo_param.

Verification
REQ-036 Reset, push 8 words 0x11..0x88 (DEPTH=8) -> wr_ready=0 after 8th, count=8, almost_full=1 from count 6; pop all -> 0x11..0x88 in order, rd_valid=0.
REQ-037 Full FIFO, wr_valid=1 and rd_ready=1 for one cycle -> one pop, no push, count=7.
REQ-038 Count=4, continuous push+pop 20 cycles -> count stays 4, pointers wrap twice, order intact.
REQ-039 Empty, push 0xA5A5A5A5 -> rd_valid=1, rd_data=0xA5A5A5A5 the following cycle.
REQ-040 Macro defined: full FIFO, wr_valid=1 3 cycles -> ovf_err=1, drop_cnt=3; err_clr -> both 0; 300 drops -> drop_cnt=255.
REQ-041 fifo_rst pulsed at count=5 mid-stream -> count=0, rd_valid=0, wr_ready=1 immediately, without waiting for a clock edge.
